// File: rtl/cmos_tx_pkg.sv
// cmos_tx_pkg: shared types and constants for the CMOS frame transmitter.
// States, pattern encodings, RGB565 bar colours and default timing.
package cmos_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    VSYNC,
    V_BACK,
    LINE,
    V_FRONT
  } state_t;

  typedef enum logic [1:0] {
    PAT_EXT   = 2'd0,
    PAT_BARS  = 2'd1,
    PAT_INCR  = 2'd2,
    PAT_BLACK = 2'd3
  } pattern_t;

  localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
  localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
  localparam logic [15:0] RGB_CYAN    = 16'h07FF;
  localparam logic [15:0] RGB_GREEN   = 16'h07E0;
  localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
  localparam logic [15:0] RGB_RED     = 16'hF800;
  localparam logic [15:0] RGB_BLUE    = 16'h001F;
  localparam logic [15:0] RGB_BLACK   = 16'h0000;

  localparam int DEF_H_ACTIVE      = 320;
  localparam int DEF_V_ACTIVE      = 240;
  localparam int DEF_H_BLANK       = 144;
  localparam int DEF_VSYNC_LINES   = 3;
  localparam int DEF_V_BACK_LINES  = 17;
  localparam int DEF_V_FRONT_LINES = 10;
  localparam int DEF_ADDR_WIDTH    = 17;

  function automatic logic [15:0] bar_colour(
    input logic [2:0] idx
  );
    logic [15:0] c;
    unique case (idx)
      3'd0: c = RGB_WHITE;
      3'd1: c = RGB_YELLOW;
      3'd2: c = RGB_CYAN;
      3'd3: c = RGB_GREEN;
      3'd4: c = RGB_MAGENTA;
      3'd5: c = RGB_RED;
      3'd6: c = RGB_BLUE;
      3'd7: c = RGB_BLACK;
    endcase
    return c;
  endfunction

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/cmos_frame_transmitter_pattern_gen.sv
// cmos_test_pattern_gen: combinational RGB565 test-pattern source.
// Bars by column, incrementing by pixel index, or black.
module cmos_test_pattern_gen
  import cmos_tx_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int X_W        = 9,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic [X_W-1:0]        x,
  input  logic [ADDR_WIDTH-1:0] n,
  input  pattern_t              sel,
  output logic [15:0]           pixel
);

  localparam int BAR_W = H_ACTIVE / 8;

  logic [2:0]  bar;
  logic [15:0] incr;

  if (ADDR_WIDTH > 16) begin : g_wide
    logic unused_n_hi;
    assign unused_n_hi = ^n[ADDR_WIDTH-1:16];
    assign incr = n[15:0];
  end else if (ADDR_WIDTH == 16) begin : g_even
    assign incr = n;
  end else begin : g_narrow
    assign incr = {{(16-ADDR_WIDTH){1'b0}}, n};
  end

  // Columns past the eighth bar boundary stay on the last bar.
  always_comb begin
    bar = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (int'(x) >= i * BAR_W) bar = 3'(i);
    end
  end

  always_comb begin
    pixel = 16'h0000;
    unique case (sel)
      PAT_BARS:  pixel = bar_colour(bar);
      PAT_INCR:  pixel = incr;
      PAT_EXT:   pixel = 16'h0000;
      PAT_BLACK: pixel = 16'h0000;
    endcase
  end

endmodule

// File: rtl/cmos_frame_transmitter.sv
// cmos_frame_transmitter: camera-side parallel CMOS link emulator.
// Streams RGB565 frames as VSYNC/HREF/byte from memory or test patterns.
module cmos_frame_transmitter
  import cmos_tx_pkg::*;
#(
  parameter int H_ACTIVE      = DEF_H_ACTIVE,
  parameter int V_ACTIVE      = DEF_V_ACTIVE,
  parameter int H_BLANK       = DEF_H_BLANK,
  parameter int VSYNC_LINES   = DEF_VSYNC_LINES,
  parameter int V_BACK_LINES  = DEF_V_BACK_LINES,
  parameter int V_FRONT_LINES = DEF_V_FRONT_LINES,
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH
) (
  input  logic                  pixel_clk_cmos_i,
  input  logic                  reset_i,
  input  logic                  enable_i,
  input  logic [1:0]            pattern_sel_i,
  output logic [ADDR_WIDTH-1:0] pixel_addr_o,
  input  logic [15:0]           pixel_data_i,
  output logic                  vsync_cmos_o,
  output logic                  href_cmos_o,
  output logic [7:0]            pixel_data_cmos_o,
  output logic                  frame_done_o
);

  localparam int LINE_CLKS = 2 * H_ACTIVE + H_BLANK;
  localparam int MAX_LINES =
    max3(VSYNC_LINES, V_BACK_LINES, V_FRONT_LINES);
  localparam int CNT_W  = $clog2(MAX_LINES * LINE_CLKS);
  localparam int X_W    = $clog2(H_ACTIVE);
  localparam int ROW_W  = $clog2(V_ACTIVE + 1);

  localparam logic [CNT_W-1:0] VS_LAST =
    CNT_W'(VSYNC_LINES * LINE_CLKS - 1);
  localparam logic [CNT_W-1:0] VB_LAST =
    CNT_W'(V_BACK_LINES * LINE_CLKS - 1);
  localparam logic [CNT_W-1:0] VF_LAST =
    CNT_W'(V_FRONT_LINES * LINE_CLKS - 1);
  localparam logic [CNT_W-1:0] LINE_LAST =
    CNT_W'(LINE_CLKS - 1);
  localparam logic [CNT_W-1:0] ACT_CLKS =
    CNT_W'(2 * H_ACTIVE);
  localparam logic [ROW_W-1:0] LAST_ROW =
    ROW_W'(V_ACTIVE - 1);
  localparam logic [ADDR_WIDTH-1:0] PIX_LAST =
    ADDR_WIDTH'(H_ACTIVE * V_ACTIVE - 1);

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [ROW_W-1:0] row;
  pattern_t         sel;

  logic        line_end;
  logic        frame_end;
  logic        load_sel;
  logic        active;
  logic        hi_phase;
  logic        lo_phase;
  logic [15:0] pat_pixel;
  logic [15:0] src;

  logic                  vsync_n;
  logic                  href_n;
  logic                  done_n;
  logic [7:0]            data_n;
  logic [7:0]            lo_q;
  logic [7:0]            lo_n;
  logic [ADDR_WIDTH-1:0] addr_n;

  assign line_end  = (state == LINE) && (cnt == LINE_LAST);
  assign frame_end = (state == V_FRONT) && (cnt == VF_LAST);
  assign load_sel  = (state_n == VSYNC) && (state != VSYNC);

  always_ff @(posedge pixel_clk_cmos_i or posedge reset_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (enable_i) state_n = VSYNC;
      VSYNC:   if (cnt == VS_LAST) state_n = V_BACK;
      V_BACK:  if (cnt == VB_LAST) state_n = LINE;
      LINE:    if (line_end && row == LAST_ROW)
                 state_n = V_FRONT;
      V_FRONT: if (frame_end)
                 state_n = enable_i ? VSYNC : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Counters restart on every state entry; select is frozen per frame.
  always_ff @(posedge pixel_clk_cmos_i or posedge reset_i) begin
    if (reset_i) begin
      cnt <= '0;
      row <= '0;
      sel <= PAT_EXT;
    end else begin
      if (state_n != state || state == IDLE || line_end)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
      if (state != LINE)
        row <= '0;
      else if (line_end)
        row <= row + 1'b1;
      if (load_sel)
        sel <= pattern_t'(pattern_sel_i);
    end
  end

  cmos_test_pattern_gen #(
    .H_ACTIVE   (H_ACTIVE),
    .X_W        (X_W),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_pattern (
    .x     (cnt[X_W:1]),
    .n     (pixel_addr_o),
    .sel   (sel),
    .pixel (pat_pixel)
  );

  assign active   = (state == LINE) && (cnt < ACT_CLKS);
  assign hi_phase = active && !cnt[0];
  assign lo_phase = active && cnt[0];
  assign src      = (sel == PAT_EXT) ? pixel_data_i : pat_pixel;

  // The high-byte edge captures memory data and advances the address.
  always_comb begin
    vsync_n = (state == VSYNC);
    href_n  = active;
    done_n  = frame_end;
    data_n  = 8'h00;
    lo_n    = lo_q;
    addr_n  = pixel_addr_o;
    unique case (1'b1)
      (state == IDLE || state == VSYNC): addr_n = '0;
      hi_phase: begin
        data_n = src[15:8];
        lo_n   = src[7:0];
        addr_n = (pixel_addr_o == PIX_LAST) ?
                 PIX_LAST : pixel_addr_o + 1'b1;
      end
      lo_phase: data_n = lo_q;
      default: ;
    endcase
  end

  always_ff @(posedge pixel_clk_cmos_i or posedge reset_i) begin
    if (reset_i) begin
      vsync_cmos_o      <= 1'b0;
      href_cmos_o       <= 1'b0;
      pixel_data_cmos_o <= 8'h00;
      frame_done_o      <= 1'b0;
      pixel_addr_o      <= '0;
      lo_q              <= 8'h00;
    end else begin
      vsync_cmos_o      <= vsync_n;
      href_cmos_o       <= href_n;
      pixel_data_cmos_o <= data_n;
      frame_done_o      <= done_n;
      pixel_addr_o      <= addr_n;
      lo_q              <= lo_n;
    end
  end

endmodule
